alu_op_translator: RTL

//  Parametrised successor to the single-stage ALU opcode controller. Translates

---
 rtl/alu_op_translator.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alu_op_translator.sv
`default_nettype none
// ============================================================================
// Module  : alu_op_translator
// Brief   : Opcode -> ALU opcode translation through a programmable per-class
//           remap table, buffered in a DEPTH-entry valid/ready FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module alu_op_translator #(
  parameter int             OPW     = 8,
  parameter int             CLASS_W = 4,
  parameter int             DEPTH   = 2,
  parameter logic [OPW-1:0] ADDU_OP = 8'h06,
  parameter logic [OPW-1:0] NOP_OP  = 8'h00
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OPW-1:0]             in_opcode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPW-1:0]             out_aluop,
  input  logic                       cfg_we,
  input  logic [CLASS_W-1:0]         cfg_class,
  input  logic [1:0]                 cfg_mode,
  input  logic                       err_clr,
  output logic                       err_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int c_cw      = $clog2(DEPTH + 1);
  localparam int c_pw      = $clog2(DEPTH);
  localparam int c_entries = 2 ** CLASS_W;

  localparam logic [1:0] c_pass    = 2'b00;
  localparam logic [1:0] c_addu    = 2'b01;
  localparam logic [1:0] c_class   = 2'b10;
  localparam logic [1:0] c_illegal = 2'b11;

  localparam logic [c_cw-1:0] c_full  = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_one_c = c_cw'(1);
  localparam logic [c_pw-1:0] c_one_p = c_pw'(1);

  function automatic logic [1:0] f_default(input int idx);
    if (idx == 0 || idx == 8 || idx == c_entries - 1) return c_pass;
    else if (idx == 4)                                 return c_addu;
    else                                               return c_class;
  endfunction

  logic [1:0]      r_table [c_entries];
  logic [OPW-1:0]  r_mem   [DEPTH];
  logic [c_pw-1:0] r_wptr;
  logic [c_pw-1:0] r_rptr;
  logic [c_cw-1:0] r_count;
  logic [OPW-1:0]  r_out;
  logic            r_err;

  logic [CLASS_W-1:0] w_class;
  logic [1:0]         w_mode;
  logic [OPW-1:0]     w_xlat;
  logic               w_push;
  logic               w_pop;
  logic [c_pw-1:0]    w_rptr_nxt;
  logic [c_cw-1:0]    w_old_left;

  assign w_class = in_opcode[OPW-1 -: CLASS_W];
  assign w_mode  = r_table[w_class];

  always_comb begin
    w_xlat = in_opcode;
    case (w_mode)
      c_pass:  w_xlat = in_opcode;
      c_addu:  w_xlat = ADDU_OP;
      c_class: w_xlat = {{(OPW-CLASS_W){1'b0}}, w_class};
      default: w_xlat = NOP_OP;
    endcase
  end

  assign in_ready    = (r_count < c_full);
  assign out_valid   = (r_count != '0);
  assign w_push      = in_valid & in_ready;
  assign w_pop       = out_valid & out_ready;
  assign w_rptr_nxt  = w_pop ? r_rptr + c_one_p : r_rptr;
  assign w_old_left  = w_pop ? r_count - c_one_c : r_count;
  assign out_aluop   = r_out;
  assign err_illegal = r_err;
  assign count       = r_count;

  // Table lookup for an accepted opcode uses the pre-write entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_entries; i++) r_table[i] <= f_default(i);
    end else if (cfg_we) begin
      r_table[cfg_class] <= cfg_mode;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= w_xlat;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_out   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_one_p;
      r_rptr <= w_rptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_one_c;
        2'b01:   r_count <= r_count - c_one_c;
        default: r_count <= r_count;
      endcase
      // Head register: next older entry if any remain, else the new push, else hold.
      if (w_old_left != '0) r_out <= r_mem[w_rptr_nxt];
      else if (w_push)      r_out <= w_xlat;
      if (w_push && w_mode == c_illegal) r_err <= 1'b1;
      else if (err_clr)                  r_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire
